// File: rtl/mem_wb_pkg.sv
// Shared processor constants for the MEM/WB boundary.
// Widths, register count and the write-back bubble.
package mem_wb_pkg;

    localparam int MW_DATA_WIDTH = 16;
    localparam int MW_REG_COUNT  = 8;
    localparam int MW_ADDR_WIDTH = 3;
    localparam int MW_CNT_WIDTH  = 16;

    typedef struct packed {
        logic memtoreg;
        logic reglow;
        logic reghigh;
    } wb_ctrl_t;

    localparam wb_ctrl_t WB_CTRL_BUBBLE = '{
        memtoreg: 1'b0,
        reglow:   1'b0,
        reghigh:  1'b0
    };

    localparam logic [MW_ADDR_WIDTH-1:0] ADDR_BUBBLE = '0;

endpackage

// File: rtl/mem_wb_reg_file.sv
// General register file: two write ports, two read ports.
// Reads see same-cycle writes; the low port wins on a clash.
module mem_wb_reg_file #(
    parameter int DATA_WIDTH = 16,
    parameter int REG_COUNT  = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_we_lo,
    input  logic [ADDR_WIDTH-1:0] i_waddr_lo,
    input  logic [DATA_WIDTH-1:0] i_wdata_lo,
    input  logic                  i_we_hi,
    input  logic [ADDR_WIDTH-1:0] i_waddr_hi,
    input  logic [DATA_WIDTH-1:0] i_wdata_hi,
    input  logic [ADDR_WIDTH-1:0] i_raddr_a,
    input  logic [ADDR_WIDTH-1:0] i_raddr_b,
    output logic [DATA_WIDTH-1:0] o_rdata_a,
    output logic [DATA_WIDTH-1:0] o_rdata_b
);

    logic [DATA_WIDTH-1:0] r_regs [REG_COUNT];
    logic                  w_hi_ok;

    // High port is suppressed when the low port targets the same register.
    assign w_hi_ok = i_we_hi &&
                     !(i_we_lo && (i_waddr_lo == i_waddr_hi));

    // Commit both write ports; reset clears every register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (i_we_lo) begin
                r_regs[i_waddr_lo] <= i_wdata_lo;
            end
            if (w_hi_ok) begin
                r_regs[i_waddr_hi] <= i_wdata_hi;
            end
        end
    end

    // Read port A with write-through, low port first.
    always_comb begin
        o_rdata_a = r_regs[i_raddr_a];
        if (i_we_lo && (i_waddr_lo == i_raddr_a)) begin
            o_rdata_a = i_wdata_lo;
        end else if (i_we_hi && (i_waddr_hi == i_raddr_a)) begin
            o_rdata_a = i_wdata_hi;
        end
    end

    // Read port B with write-through, low port first.
    always_comb begin
        o_rdata_b = r_regs[i_raddr_b];
        if (i_we_lo && (i_waddr_lo == i_raddr_b)) begin
            o_rdata_b = i_wdata_lo;
        end else if (i_we_hi && (i_waddr_hi == i_raddr_b)) begin
            o_rdata_b = i_wdata_hi;
        end
    end

endmodule

// File: rtl/mem_wb.sv
// MEM/WB pipeline latch, write-back mux and retire counter.
// Each captured entry writes and counts only in its first cycle.
module mem_wb
    import mem_wb_pkg::*;
#(
    parameter int DATA_WIDTH = MW_DATA_WIDTH,
    parameter int REG_COUNT  = MW_REG_COUNT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     stall_in,
    input  logic                     flush_in,
    input  logic [MW_ADDR_WIDTH-1:0] Rdst1_in,
    input  logic [DATA_WIDTH-1:0]    Rdst1_val_in,
    input  logic [MW_ADDR_WIDTH-1:0] Rdst2_in,
    input  logic [DATA_WIDTH-1:0]    Rdst2_val_in,
    input  logic [DATA_WIDTH-1:0]    Data_in,
    input  logic                     memToReg_in,
    input  logic                     reglow_write_in,
    input  logic                     reghigh_write_in,
    input  logic [MW_ADDR_WIDTH-1:0] rd_addr_a,
    input  logic [MW_ADDR_WIDTH-1:0] rd_addr_b,
    output logic [DATA_WIDTH-1:0]    rd_data_a,
    output logic [DATA_WIDTH-1:0]    rd_data_b,
    output logic [DATA_WIDTH-1:0]    DATA_Rdst1_WB_out,
    output logic [DATA_WIDTH-1:0]    Rdst2_WB_out,
    output logic [MW_ADDR_WIDTH-1:0] Rdst1_WB_out,
    output logic [MW_ADDR_WIDTH-1:0] Rdst2_WB_addr_out,
    output logic                     reglow_write_WB_out,
    output logic                     reghigh_write_WB_out,
    output logic [MW_CNT_WIDTH-1:0]  retired_count_out
);

    wb_ctrl_t                 r_ctrl;
    logic [MW_ADDR_WIDTH-1:0] r_rdst1;
    logic [MW_ADDR_WIDTH-1:0] r_rdst2;
    logic [DATA_WIDTH-1:0]    r_rdst1_val;
    logic [DATA_WIDTH-1:0]    r_rdst2_val;
    logic [DATA_WIDTH-1:0]    r_data;
    logic                     r_fresh;
    logic [MW_CNT_WIDTH-1:0]  r_count;

    logic                     w_we_lo;
    logic                     w_we_hi;
    logic [DATA_WIDTH-1:0]    w_wb1;

    // Pipeline latch: flush beats stall; stall holds and retires freshness.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ctrl      <= WB_CTRL_BUBBLE;
            r_rdst1     <= ADDR_BUBBLE;
            r_rdst2     <= ADDR_BUBBLE;
            r_rdst1_val <= '0;
            r_rdst2_val <= '0;
            r_data      <= '0;
            r_fresh     <= 1'b0;
        end else if (flush_in) begin
            r_ctrl      <= WB_CTRL_BUBBLE;
            r_rdst1     <= ADDR_BUBBLE;
            r_rdst2     <= ADDR_BUBBLE;
            r_rdst1_val <= '0;
            r_rdst2_val <= '0;
            r_data      <= '0;
            r_fresh     <= 1'b0;
        end else if (!stall_in) begin
            r_ctrl.memtoreg <= memToReg_in;
            r_ctrl.reglow   <= reglow_write_in;
            r_ctrl.reghigh  <= reghigh_write_in;
            r_rdst1         <= Rdst1_in;
            r_rdst2         <= Rdst2_in;
            r_rdst1_val     <= Rdst1_val_in;
            r_rdst2_val     <= Rdst2_val_in;
            r_data          <= Data_in;
            r_fresh         <= 1'b1;
        end else begin
            r_fresh <= 1'b0;
        end
    end

    assign w_we_lo = r_fresh & r_ctrl.reglow;
    assign w_we_hi = r_fresh & r_ctrl.reghigh;
    assign w_wb1   = r_ctrl.memtoreg ? r_data : r_rdst1_val;

    // Retire counter: one tick per committed entry, wraps naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (w_we_lo || w_we_hi) begin
            r_count <= r_count + MW_CNT_WIDTH'(1);
        end
    end

    mem_wb_reg_file #(
        .DATA_WIDTH (DATA_WIDTH),
        .REG_COUNT  (REG_COUNT),
        .ADDR_WIDTH (MW_ADDR_WIDTH)
    ) u_rf (
        .clk        (clk),
        .reset      (reset),
        .i_we_lo    (w_we_lo),
        .i_waddr_lo (r_rdst1),
        .i_wdata_lo (w_wb1),
        .i_we_hi    (w_we_hi),
        .i_waddr_hi (r_rdst2),
        .i_wdata_hi (r_rdst2_val),
        .i_raddr_a  (rd_addr_a),
        .i_raddr_b  (rd_addr_b),
        .o_rdata_a  (rd_data_a),
        .o_rdata_b  (rd_data_b)
    );

    assign DATA_Rdst1_WB_out    = w_wb1;
    assign Rdst2_WB_out         = r_rdst2_val;
    assign Rdst1_WB_out         = r_rdst1;
    assign Rdst2_WB_addr_out    = r_rdst2;
    assign reglow_write_WB_out  = r_ctrl.reglow;
    assign reghigh_write_WB_out = r_ctrl.reghigh;
    assign retired_count_out    = r_count;

endmodule

// File: tb/tb_mem_wb.sv
// Directed bench for mem_wb.
// Each task drives one scenario and checks inline.
module tb_mem_wb;

    logic        clk;
    logic        reset;
    logic        stall_in;
    logic        flush_in;
    logic [2:0]  Rdst1_in;
    logic [15:0] Rdst1_val_in;
    logic [2:0]  Rdst2_in;
    logic [15:0] Rdst2_val_in;
    logic [15:0] Data_in;
    logic        memToReg_in;
    logic        reglow_write_in;
    logic        reghigh_write_in;
    logic [2:0]  rd_addr_a;
    logic [2:0]  rd_addr_b;
    logic [15:0] rd_data_a;
    logic [15:0] rd_data_b;
    logic [15:0] DATA_Rdst1_WB_out;
    logic [15:0] Rdst2_WB_out;
    logic [2:0]  Rdst1_WB_out;
    logic [2:0]  Rdst2_WB_addr_out;
    logic        reglow_write_WB_out;
    logic        reghigh_write_WB_out;
    logic [15:0] retired_count_out;

    int checks;
    int failures;

    mem_wb dut (
        .clk                  (clk),
        .reset                (reset),
        .stall_in             (stall_in),
        .flush_in             (flush_in),
        .Rdst1_in             (Rdst1_in),
        .Rdst1_val_in         (Rdst1_val_in),
        .Rdst2_in             (Rdst2_in),
        .Rdst2_val_in         (Rdst2_val_in),
        .Data_in              (Data_in),
        .memToReg_in          (memToReg_in),
        .reglow_write_in      (reglow_write_in),
        .reghigh_write_in     (reghigh_write_in),
        .rd_addr_a            (rd_addr_a),
        .rd_addr_b            (rd_addr_b),
        .rd_data_a            (rd_data_a),
        .rd_data_b            (rd_data_b),
        .DATA_Rdst1_WB_out    (DATA_Rdst1_WB_out),
        .Rdst2_WB_out         (Rdst2_WB_out),
        .Rdst1_WB_out         (Rdst1_WB_out),
        .Rdst2_WB_addr_out    (Rdst2_WB_addr_out),
        .reglow_write_WB_out  (reglow_write_WB_out),
        .reghigh_write_WB_out (reghigh_write_WB_out),
        .retired_count_out    (retired_count_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        stall_in         = 1'b0;
        flush_in         = 1'b0;
        Rdst1_in         = 3'd0;
        Rdst1_val_in     = 16'h0;
        Rdst2_in         = 3'd0;
        Rdst2_val_in     = 16'h0;
        Data_in          = 16'h0;
        memToReg_in      = 1'b0;
        reglow_write_in  = 1'b0;
        reghigh_write_in = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle();
        rd_addr_a = 3'd0;
        rd_addr_b = 3'd7;
        #3;
        checks++;
        if ({DATA_Rdst1_WB_out, Rdst2_WB_out, rd_data_a,
             rd_data_b, retired_count_out} !== 80'h0) begin
            failures++;
            $display("FAIL reset_data got %h %h %h %h %h exp 0",
                     DATA_Rdst1_WB_out, Rdst2_WB_out,
                     rd_data_a, rd_data_b, retired_count_out);
        end
        checks++;
        if ({Rdst1_WB_out, Rdst2_WB_addr_out, reglow_write_WB_out,
             reghigh_write_WB_out} !== 8'h0) begin
            failures++;
            $display("FAIL reset_ctrl got %h %h %b %b exp 0",
                     Rdst1_WB_out, Rdst2_WB_addr_out,
                     reglow_write_WB_out, reghigh_write_WB_out);
        end
        tick();
        tick();
        #2;
        reset = 1'b1;
    endtask

    task automatic test_alu_write();
        @(negedge clk);
        Rdst1_in        = 3'd3;
        Rdst1_val_in    = 16'h1234;
        Data_in         = 16'hDEAD;
        reglow_write_in = 1'b1;
        tick();
        idle();
        rd_addr_a = 3'd3;
        #1;
        checks++;
        if (DATA_Rdst1_WB_out !== 16'h1234) begin
            failures++;
            $display("FAIL alu_wb got %h exp 1234", DATA_Rdst1_WB_out);
        end
        checks++;
        if (retired_count_out !== 16'd0) begin
            failures++;
            $display("FAIL alu_cnt_pre got %0d exp 0", retired_count_out);
        end
        tick();
        checks++;
        if (rd_data_a !== 16'h1234) begin
            failures++;
            $display("FAIL alu_r3 got %h exp 1234", rd_data_a);
        end
        checks++;
        if (retired_count_out !== 16'd1) begin
            failures++;
            $display("FAIL alu_cnt got %0d exp 1", retired_count_out);
        end
    endtask

    task automatic test_mem_write();
        @(negedge clk);
        Rdst1_in        = 3'd5;
        Rdst1_val_in    = 16'h1111;
        Data_in         = 16'hBEEF;
        memToReg_in     = 1'b1;
        reglow_write_in = 1'b1;
        tick();
        idle();
        rd_addr_a = 3'd5;
        #1;
        checks++;
        if (rd_data_a !== 16'hBEEF) begin
            failures++;
            $display("FAIL mem_wthru got %h exp beef", rd_data_a);
        end
        tick();
        checks++;
        if (rd_data_a !== 16'hBEEF) begin
            failures++;
            $display("FAIL mem_r5 got %h exp beef", rd_data_a);
        end
        checks++;
        if (retired_count_out !== 16'd2) begin
            failures++;
            $display("FAIL mem_cnt got %0d exp 2", retired_count_out);
        end
    endtask

    task automatic test_same_addr();
        @(negedge clk);
        Rdst1_in         = 3'd2;
        Rdst1_val_in     = 16'hAAAA;
        Rdst2_in         = 3'd2;
        Rdst2_val_in     = 16'h5555;
        reglow_write_in  = 1'b1;
        reghigh_write_in = 1'b1;
        tick();
        idle();
        rd_addr_a = 3'd2;
        #1;
        checks++;
        if (rd_data_a !== 16'hAAAA) begin
            failures++;
            $display("FAIL same_wthru got %h exp aaaa", rd_data_a);
        end
        checks++;
        if (Rdst2_WB_out !== 16'h5555) begin
            failures++;
            $display("FAIL same_wb2 got %h exp 5555", Rdst2_WB_out);
        end
        tick();
        checks++;
        if (rd_data_a !== 16'hAAAA) begin
            failures++;
            $display("FAIL same_r2 got %h exp aaaa", rd_data_a);
        end
        checks++;
        if (retired_count_out !== 16'd3) begin
            failures++;
            $display("FAIL same_cnt got %0d exp 3", retired_count_out);
        end
    endtask

    task automatic test_stall();
        @(negedge clk);
        Rdst1_in        = 3'd4;
        Rdst1_val_in    = 16'h0042;
        reglow_write_in = 1'b1;
        tick();
        stall_in     = 1'b1;
        Rdst1_val_in = 16'h9999;
        rd_addr_a    = 3'd4;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (DATA_Rdst1_WB_out !== 16'h0042 ||
                reglow_write_WB_out !== 1'b1) begin
                failures++;
                $display("FAIL stall_hold%0d got %h/%b exp 0042/1",
                         k, DATA_Rdst1_WB_out, reglow_write_WB_out);
            end
            checks++;
            if (retired_count_out !== 16'd4) begin
                failures++;
                $display("FAIL stall_cnt%0d got %0d exp 4",
                         k, retired_count_out);
            end
        end
        checks++;
        if (rd_data_a !== 16'h0042) begin
            failures++;
            $display("FAIL stall_r4 got %h exp 0042", rd_data_a);
        end
        idle();
        tick();
    endtask

    task automatic test_flush();
        @(negedge clk);
        stall_in         = 1'b1;
        flush_in         = 1'b1;
        Rdst1_in         = 3'd6;
        Rdst1_val_in     = 16'h7777;
        Rdst2_in         = 3'd7;
        Rdst2_val_in     = 16'h8888;
        reglow_write_in  = 1'b1;
        reghigh_write_in = 1'b1;
        tick();
        checks++;
        if (reglow_write_WB_out !== 1'b0 ||
            reghigh_write_WB_out !== 1'b0 ||
            DATA_Rdst1_WB_out !== 16'h0) begin
            failures++;
            $display("FAIL flush_bubble got %b %b %h exp 0 0 0",
                     reglow_write_WB_out, reghigh_write_WB_out,
                     DATA_Rdst1_WB_out);
        end
        idle();
        rd_addr_a = 3'd6;
        rd_addr_b = 3'd7;
        tick();
        checks++;
        if (rd_data_a !== 16'h0 || rd_data_b !== 16'h0) begin
            failures++;
            $display("FAIL flush_nowrite got %h %h exp 0 0",
                     rd_data_a, rd_data_b);
        end
        checks++;
        if (retired_count_out !== 16'd4) begin
            failures++;
            $display("FAIL flush_cnt got %0d exp 4", retired_count_out);
        end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        Rdst1_in        = 3'd1;
        reglow_write_in = 1'b1;
        for (int k = 0; k < 65531; k++) begin
            Rdst1_val_in = 16'(k);
            tick();
        end
        idle();
        tick();
        checks++;
        if (retired_count_out !== 16'hFFFF) begin
            failures++;
            $display("FAIL wrap_pre got %h exp ffff", retired_count_out);
        end
        Rdst1_in        = 3'd1;
        Rdst1_val_in    = 16'h0101;
        reglow_write_in = 1'b1;
        tick();
        idle();
        tick();
        checks++;
        if (retired_count_out !== 16'h0000) begin
            failures++;
            $display("FAIL wrap got %h exp 0000", retired_count_out);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        Rdst1_in        = 3'd1;
        Rdst1_val_in    = 16'hABCD;
        reglow_write_in = 1'b1;
        tick();
        rd_addr_a = 3'd1;
        rd_addr_b = 3'd3;
        #1;
        checks++;
        if (rd_data_a !== 16'hABCD) begin
            failures++;
            $display("FAIL rst_pre got %h exp abcd", rd_data_a);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({DATA_Rdst1_WB_out, Rdst2_WB_out, rd_data_a,
             rd_data_b, retired_count_out} !== 80'h0) begin
            failures++;
            $display("FAIL rst_mid got %h %h %h %h %h exp 0",
                     DATA_Rdst1_WB_out, Rdst2_WB_out,
                     rd_data_a, rd_data_b, retired_count_out);
        end
        checks++;
        if ({Rdst1_WB_out, reglow_write_WB_out} !== 4'h0) begin
            failures++;
            $display("FAIL rst_mid_ctrl got %h %b exp 0 0",
                     Rdst1_WB_out, reglow_write_WB_out);
        end
        tick();
        checks++;
        if (rd_data_a !== 16'h0 || retired_count_out !== 16'h0) begin
            failures++;
            $display("FAIL rst_edge got %h %0d exp 0 0",
                     rd_data_a, retired_count_out);
        end
        #2;
        reset = 1'b1;
        tick();
        checks++;
        if (reglow_write_WB_out !== 1'b1 || Rdst1_WB_out !== 3'd1) begin
            failures++;
            $display("FAIL rst_first got %b %0d exp 1 1",
                     reglow_write_WB_out, Rdst1_WB_out);
        end
        idle();
        tick();
        checks++;
        if (rd_data_a !== 16'hABCD || retired_count_out !== 16'd1) begin
            failures++;
            $display("FAIL rst_after got %h %0d exp abcd 1",
                     rd_data_a, retired_count_out);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_alu_write();
        test_mem_write();
        test_same_addr();
        test_stall();
        test_flush();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_wb.md
MEM_WB -- requirements
Module: mem_wb

Interface
REQ-001 Parameter DATA_WIDTH, default 16, width of every register and data value.
REQ-002 Parameter REG_COUNT, default 8, number of general registers; address width is 3.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low; clears all state immediately when low.
REQ-005 stall_in  in  1  hold the MEM/WB latch (upstream MEM stage is stalling).
REQ-006 flush_in  in  1  load a bubble into the latch.
REQ-007 Rdst1_in  in  3 / Rdst1_val_in  in  16 / Rdst2_in  in  3 / Rdst2_val_in  in  16  destinations and ALU values from MEM.
REQ-008 Data_in  in  16  memory or port data from MEM; memToReg_in  in  1  selects Data_in for Rdst1.
REQ-009 reglow_write_in  in  1  write Rdst1; reghigh_write_in  in  1  write Rdst2.
REQ-010 rd_addr_a, rd_addr_b  in  3  decode read addresses; rd_data_a, rd_data_b  out  16  read data.
REQ-011 DATA_Rdst1_WB_out  out  16 / Rdst2_WB_out  out  16  write-back values, also sent to forwarding unit 2 and MEM.
REQ-012 Rdst1_WB_out, Rdst2_WB_addr_out  out  3 / reglow_write_WB_out, reghigh_write_WB_out  out  1  latched destinations and enables.
REQ-013 retired_count_out  out  16  count of committed write-back entries.

Function
REQ-014 Latch captures all REQ-007..009 inputs on each rising clk edge when stall_in=0 and flush_in=0.
REQ-015 stall_in=1 (flush_in=0): latch holds its value; held entry SHALL NOT be rewritten or recounted on later cycles.
REQ-016 flush_in=1: latch loads bubble (both enables 0, addresses 0, values 0); flush overrides stall.
REQ-017 DATA_Rdst1_WB_out = latched memToReg ? latched Data : latched Rdst1_val; Rdst2_WB_out = latched Rdst2_val; combinational from latch, 1-cycle latency from MEM.
REQ-018 Register file: on rising clk, writes DATA_Rdst1_WB_out to Rdst1 if reglow enable, Rdst2_WB_out to Rdst2 if reghigh enable; writes occur only in the first cycle an entry is present (write-once flag).
REQ-019 Both enables, same address: Rdst1 (low port) value wins.
REQ-020 Reads combinational with write-through: reading an address being written this cycle returns the new value; low port priority per REQ-019.
REQ-021 retired_count increments by 1 per committed entry (either enable set, first cycle only); bubbles not counted; wraps 0xFFFF -> 0x0000.
REQ-022 Write-once flag: set on capture, cleared after the first cycle; stall keeps it cleared; flush clears it.

Reset
REQ-023 reset low: latch = bubble, all registers = 0, retired_count = 0, write-once flag = 0; all outputs read 0.
REQ-024 reset asserted mid-write: no write is committed on the edge where reset is low; first capture occurs on the first rising edge after release.

Structure
REQ-025 DATA_WIDTH, REG_COUNT, address width and the bubble constant live in the shared processor package.
REQ-026 One sub-module reg_file (REG_COUNT x DATA_WIDTH, two write ports, two write-through read ports); latch, mux and counter stay in mem_wb.

Verification
REQ-027 Rdst1=3, Rdst1_val=0x1234, memToReg=0, reglow=1 -> next cycle DATA_Rdst1_WB_out=0x1234; after edge rd_addr_a=3 reads 0x1234; count=1.
REQ-028 memToReg=1, Data_in=0xBEEF, Rdst1=5 -> R5=0xBEEF; same-cycle read of 5 during write returns 0xBEEF.
REQ-029 Rdst1=Rdst2=2, values 0xAAAA/0x5555, both enables -> R2=0xAAAA.
REQ-030 Capture entry then stall_in=1 for 3 cycles -> outputs held, count increases by 1 only, register written once.
REQ-031 flush_in=1 with stall_in=1 and valid inputs -> enables 0, no write, count unchanged.
REQ-032 Preload count 0xFFFF, commit one entry -> count 0x0000; assert reset mid-cycle -> all outputs 0 immediately.
